// File: rtl/lsu_bus_bridge.sv
// Load/store bridge from the memory pipeline stage to a valid/ready word bus.
// Optional bus wait timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_data,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [1:0]  memory_size,
    input  logic        load_store_unsigned,
    output logic [31:0] memory_read_data,
    output logic        mem_stall,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t      state, state_next;
    logic        request, access_bad, capture, expired, timeout;
    logic [3:0]  lanes;
    logic [31:0] load_value;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Shift the addressed lane down, then sign- or zero-extend it.
    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [31:0]        s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        s = rdata >> {off, 3'b000};
        b = s[7:0];
        h = s[15:0];
        case (size)
            2'd0:    extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: extract = s;
        endcase
    endfunction

    assign request    = memory_read | memory_write;
    assign bus_addr   = {memory_address[31:2], 2'b00};
    assign load_value = extract(bus_rdata, memory_address[1:0], memory_size, load_store_unsigned);

    always_comb begin
        case (memory_size)
            2'd0:    access_bad = 1'b0;
            2'd1:    access_bad = memory_address[0];
            2'd2:    access_bad = (memory_address[1:0] != 2'b00);
            default: access_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (memory_size)
            2'd0: begin
                bus_wdata = {4{memory_write_data[7:0]}};
                lanes     = 4'b0001 << memory_address[1:0];
            end
            2'd1: begin
                bus_wdata = {2{memory_write_data[15:0]}};
                lanes     = 4'b0011 << memory_address[1:0];
            end
            default: begin
                bus_wdata = memory_write_data;
                lanes     = 4'b1111;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero in IDLE so every transaction enters REQ with a fresh count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == REQ || state == WAIT_R)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    assign timeout   = (state == REQ || state == WAIT_R) && (wait_cnt == CNT_LAST);
    assign bus_error = expired;
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        misaligned = 1'b0;
        capture    = 1'b0;
        expired    = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    if (access_bad)
                        misaligned = 1'b1;
                    else
                        state_next = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    if (memory_write) begin
                        state_next = DONE;
                    end else if (bus_rvalid) begin
                        capture    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAIT_R;
                    end
                end else if (timeout) begin
                    expired    = 1'b1;
                    capture    = ~memory_write;
                    state_next = DONE;
                end
            end
            WAIT_R: begin
                if (bus_rvalid) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (timeout) begin
                    expired    = 1'b1;
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus_we    = bus_req & memory_write;
    assign bus_wstrb = bus_we ? lanes : 4'b0000;
    assign mem_stall = request && (state != DONE) && !access_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            memory_read_data <= '0;
        else if (capture)
            memory_read_data <= expired ? 32'h0 : load_value;
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: directed accesses push expectations,
// a monitor checks each completed access; a reactive model plays the bus.
module tb_lsu_bus_bridge;

    logic        clock, reset;
    logic [31:0] memory_address, memory_write_data, memory_read_data;
    logic        memory_read, memory_write, load_store_unsigned;
    logic [1:0]  memory_size;
    logic        mem_stall, misaligned, bus_req, bus_we, bus_gnt, bus_rvalid, bus_error;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    lsu_bus_bridge dut (
        .clock(clock), .reset(reset),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_size(memory_size), .load_store_unsigned(load_store_unsigned),
        .memory_read_data(memory_read_data), .mem_stall(mem_stall),
        .misaligned(misaligned), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_error(bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
        logic        mis;
        int          stall;
        int          reqc;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b1;

    int          gnt_delay = 0, rv_delay = 0, req_cnt = 0, rv_cnt = 0;
    logic [31:0] rdata_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Bus model: grant after gnt_delay request cycles, read data rv_delay cycles after grant.
    initial begin
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clock); #2;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (bus_req) begin
                if (req_cnt == gnt_delay) begin
                    bus_gnt = 1'b1;
                    if (!bus_we) begin
                        if (rv_delay == 0) begin
                            bus_rvalid = 1'b1; bus_rdata = rdata_val;
                        end else begin
                            rv_cnt = rv_delay;
                        end
                    end
                end
                req_cnt++;
            end else begin
                req_cnt = 0;
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        bus_rvalid = 1'b1; bus_rdata = rdata_val;
                    end
                end
            end
        end
    end

    // Monitor: an access completes on the first cycle it is presented without a stall.
    initial begin
        int          stallc = 0, reqc = 0;
        logic [31:0] s_addr = '0, s_wdata = '0;
        logic [3:0]  s_wstrb = '0;
        logic        s_we = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (mon_en && (memory_read || memory_write)) begin
                if (bus_req) begin
                    reqc++;
                    s_addr = bus_addr; s_we = bus_we; s_wdata = bus_wdata; s_wstrb = bus_wstrb;
                end
                if (mem_stall) begin
                    stallc++;
                end else if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_completion: got access with empty queue want none");
                end else begin
                    e = expq.pop_front();
                    check({e.name, "_rdata"}, memory_read_data, e.rd);
                    check({e.name, "_misaligned"}, 32'(misaligned), 32'(e.mis));
                    check({e.name, "_stall_cycles"}, 32'(stallc), 32'(e.stall));
                    check({e.name, "_req_cycles"}, 32'(reqc), 32'(e.reqc));
                    if (e.reqc > 0) begin
                        check({e.name, "_bus_addr"}, s_addr, e.addr);
                        check({e.name, "_bus_we"}, 32'(s_we), 32'(e.we));
                        check({e.name, "_bus_wstrb"}, 32'(s_wstrb), 32'(e.wstrb));
                        if (e.we) check({e.name, "_bus_wdata"}, s_wdata, e.wdata);
                    end
                    stallc = 0; reqc = 0;
                end
            end
        end
    end

    task automatic access(input string name, input logic rd_i, input logic wr_i,
                          input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rv,
                          input logic [31:0] rdata, input logic [31:0] exp_rd,
                          input logic mis, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input int exp_stall, input int exp_req);
        exp_t e;
        bit   done;
        e.name = name; e.addr = {addr[31:2], 2'b00}; e.we = wr_i; e.wdata = exp_wdata;
        e.wstrb = exp_wstrb; e.rd = exp_rd; e.mis = mis; e.stall = exp_stall; e.reqc = exp_req;
        expq.push_back(e);
        gnt_delay = gd; rv_delay = rv; rdata_val = rdata;
        @(posedge clock); #1;
        memory_address = addr; memory_write_data = wd; memory_size = sz;
        load_store_unsigned = uns; memory_read = rd_i; memory_write = wr_i;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clock);
            if (!mem_stall) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: got stall beyond 50 cycles want completion", name);
        end
        @(posedge clock); #1;
        memory_read = 1'b0; memory_write = 1'b0;
    endtask

    initial begin
        memory_address = '0; memory_write_data = '0; memory_size = 2'd0;
        load_store_unsigned = 1'b0; memory_read = 1'b0; memory_write = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_bus_req", 32'(bus_req), 32'h0);
        check("reset_bus_we", 32'(bus_we), 32'h0);
        check("reset_misaligned", 32'(misaligned), 32'h0);
        check("reset_mem_stall", 32'(mem_stall), 32'h0);
        check("reset_read_data", memory_read_data, 32'h0);
        check("reset_bus_error", 32'(bus_error), 32'h0);
        reset = 1'b0;

        //     name    rd wr sz   uns addr          wd            gd rv rdata         exp_rd        mis exp_wdata     strb     st rq
        access("lb",   1, 0, 2'd0, 0, 32'h103, 32'h0,        0, 0, 32'h80123456, 32'hFFFFFF80, 0, 32'h0,        4'b0000, 2, 1);
        access("lbu",  1, 0, 2'd0, 1, 32'h103, 32'h0,        0, 0, 32'h80123456, 32'h00000080, 0, 32'h0,        4'b0000, 2, 1);
        access("lh",   1, 0, 2'd1, 0, 32'h102, 32'h0,        0, 0, 32'hF00D1234, 32'hFFFFF00D, 0, 32'h0,        4'b0000, 2, 1);
        access("lhu",  1, 0, 2'd1, 1, 32'h102, 32'h0,        0, 0, 32'hF00D1234, 32'h0000F00D, 0, 32'h0,        4'b0000, 2, 1);
        access("sh",   0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 3, 0, 32'h0,        32'h0000F00D, 0, 32'hABCDABCD, 4'b1100, 5, 4);
        access("sb",   0, 1, 2'd0, 0, 32'h101, 32'h000000A5, 0, 0, 32'h0,        32'h0000F00D, 0, 32'hA5A5A5A5, 4'b0010, 2, 1);
        access("sw",   0, 1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 1, 0, 32'h0,        32'h0000F00D, 0, 32'hDEADBEEF, 4'b1111, 3, 2);
        access("lw_mis", 1, 0, 2'd2, 0, 32'h101, 32'h0,      0, 0, 32'h0,        32'h0000F00D, 1, 32'h0,        4'b0000, 0, 0);
        access("sz3_mis", 1, 0, 2'd3, 0, 32'h100, 32'h0,     0, 0, 32'h0,        32'h0000F00D, 1, 32'h0,        4'b0000, 0, 0);
        access("sh_mis", 0, 1, 2'd1, 0, 32'h101, 32'h5555,   0, 0, 32'h0,        32'h0000F00D, 1, 32'h0,        4'b0000, 0, 0);
        access("lw_wait", 1, 0, 2'd2, 0, 32'h104, 32'h0,     0, 2, 32'hCAFEBABE, 32'hCAFEBABE, 0, 32'h0,        4'b0000, 4, 1);
        access("lb_pos", 1, 0, 2'd0, 0, 32'h101, 32'h0,      0, 0, 32'h00007F00, 32'h0000007F, 0, 32'h0,        4'b0000, 2, 1);
        access("rw_both", 1, 1, 2'd0, 0, 32'h102, 32'h00000011, 0, 0, 32'h0,     32'h0000007F, 0, 32'h11111111, 4'b0100, 2, 1);

        // Reset while a load waits for its read data.
        mon_en = 1'b0;
        gnt_delay = 0; rv_delay = 5; rdata_val = 32'h0BADF00D;
        @(posedge clock); #1;
        memory_address = 32'h100; memory_size = 2'd2; load_store_unsigned = 1'b0;
        memory_read = 1'b1; memory_write = 1'b0;
        repeat (3) @(negedge clock);
        check("wait_r_bus_req", 32'(bus_req), 32'h0);
        check("wait_r_stall", 32'(mem_stall), 32'h1);
        reset = 1'b1;
        #1;
        check("midreset_bus_req", 32'(bus_req), 32'h0);
        check("midreset_read_data", memory_read_data, 32'h0);
        memory_read = 1'b0;
        rv_cnt = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;

        access("lw_after_reset", 1, 0, 2'd2, 0, 32'h108, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 0, 32'h0, 4'b0000, 2, 1);

        @(negedge clock);
        check("scoreboard_empty", 32'(expq.size()), 32'h0);
`ifndef LSU_TIMEOUT_EN
        check("bus_error_tied", 32'(bus_error), 32'h0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the memory pipeline stage and a valid/ready data bus.
- Consumes the stage's memory_* request signals and converts them to word-aligned bus transactions with byte strobes.
- Stalls the pipeline until the transaction completes, then returns aligned, sign- or zero-extended load data on memory_read_data.
- Detects misaligned and illegal-size accesses and suppresses them.

Parameters:
- TIMEOUT_CYCLES, 255: bus wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
- clock  input  1  single clock; all state on posedge
- reset  input  1  asynchronous, active-high reset
- memory_address  input  32  byte address from memory stage
- memory_write_data  input  32  store data, right-justified
- memory_read  input  1  load request
- memory_write  input  1  store request
- memory_size  input  2  0 byte, 1 half, 2 word, 3 illegal
- load_store_unsigned  input  1  1 = zero-extend loads
- memory_read_data  output  32  registered, extended load result
- mem_stall  output  1  hold pipeline while high
- misaligned  output  1  one-cycle pulse on a rejected access
- bus_req  output  1  request valid
- bus_we  output  1  1 = write
- bus_addr  output  32  {memory_address[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte enables; 0 on reads
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read word
- bus_error  output  1  timeout pulse (LSU_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Clock and reset: one clock, `clock`; reset is asynchronous, active-high, port `reset`.
- States: IDLE, REQ, WAIT_R, DONE.
- Reset values:
  - state = IDLE.
  - memory_read_data = 0.
  - bus_req, bus_we, misaligned, bus_error = 0.
  - Internal timeout counter = 0.
- IDLE, request present (memory_read | memory_write):
  - If both are high, treat the access as a store.
  - Misaligned if any of: size=1 and addr[0]=1; size=2 and addr[1:0]≠0; size=3.
  - Misaligned → pulse misaligned for 1 cycle, mem_stall=0, no bus_req, memory_read_data unchanged, stay IDLE.
  - Otherwise → REQ.
- mem_stall (combinational) = request present and state ≠ DONE and access not misaligned. It is high in the same cycle the request first appears.
- REQ:
  - bus_req=1; bus_we=memory_write; bus_addr, bus_wdata and bus_wstrb are driven from the live inputs, which the stalled pipeline holds stable.
  - Hold until bus_gnt.
  - Store with gnt → DONE.
  - Load with gnt and no rvalid → WAIT_R.
  - Load with gnt and rvalid in the same cycle → capture data, → DONE.
- WAIT_R: bus_req=0. On bus_rvalid, capture extended data into memory_read_data → DONE.
- DONE:
  - mem_stall=0 for exactly 1 cycle; memory_read_data is valid and the stage samples it at this edge.
  - Unconditionally → IDLE.
  - A back-to-back memory op restarts from IDLE; minimum 2 cycles per access.
- Store lanes:
  - byte: wdata = {4{wd[7:0]}}, wstrb = 4'b0001<<addr[1:0].
  - half: wdata = {2{wd[15:0]}}, wstrb = 4'b0011<<addr[1:0].
  - word: wdata = wd, wstrb = 4'b1111.
- Load extract:
  - Shift: s = bus_rdata >> (8*addr[1:0]).
  - byte: extend s[7:0]; half: extend s[15:0].
  - Extension is sign, or zero when load_store_unsigned=1.
  - word: s unchanged.
- Reset mid-transaction: return to IDLE immediately and drop bus_req. The bus must tolerate an abandoned request or outstanding read; a stray rvalid arriving in IDLE is ignored.
- memory_read_data is not updated by stores.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When the counter reaches TIMEOUT_CYCLES: pulse bus_error for 1 cycle, load memory_read_data=0 (loads only), → DONE.
- Undefined: no counter; bus_error tied 0; the bridge waits indefinitely.

Test Plan:
1. LB, addr 0x103, rdata 0x80123456, gnt and rvalid in the same cycle → bus_addr 0x100, wstrb 0000, memory_read_data 0xFFFFFF80, mem_stall high 2 cycles.
2. LBU at 0x103, same data → 0x00000080. LH at 0x102 with rdata 0xF00D1234 → 0xFFFFF00D.
3. SH at 0x102, wd 0x1234ABCD, gnt delayed 3 cycles → bus_wdata 0xABCDABCD, wstrb 1100, bus_req high 4 cycles, mem_stall low in the following DONE cycle.
4. LW at 0x101 and size=3 at 0x100 → misaligned pulse each, bus_req never asserted, mem_stall 0.
5. LW: gnt at cycle 1, rvalid 2 cycles later with 0xCAFEBABE → captured 0xCAFEBABE; reset pulsed in WAIT_R on a repeat run → state IDLE, bus_req 0, memory_read_data 0.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted → bus_error pulse after 4 cycles, memory_read_data 0, mem_stall drops next cycle.
